// File: rtl/gcd_datapath_unit_if.sv
// GCD datapath bundle: micro-op command channel from the controller,
// status flags back to it, and the result channel to the host.
interface gcd_datapath_unit_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_BITS = 5
);
  logic                 op_valid;
  logic                 op_ready;
  logic [ADDR_BITS-1:0] rf_read_addr1;
  logic [ADDR_BITS-1:0] rf_read_addr2;
  logic [ADDR_BITS-1:0] rf_write_addr;
  logic                 rf_write_en;
  logic                 rf_write_data_sel;
  logic [DATA_W-1:0]    const_val;
  logic                 alu_sel;
  logic [1:0]           alu_oper;
  logic                 op_emit;
  logic                 is_zero_result;
  logic                 lt_result;
  logic [DATA_W-1:0]    res_data;
  logic                 res_valid;
  logic                 res_ready;

  modport master (
    output op_valid, rf_read_addr1, rf_read_addr2,
    output rf_write_addr, rf_write_en, rf_write_data_sel,
    output const_val, alu_sel, alu_oper, op_emit,
    output res_ready,
    input  op_ready, is_zero_result, lt_result,
    input  res_data, res_valid
  );

  modport slave (
    input  op_valid, rf_read_addr1, rf_read_addr2,
    input  rf_write_addr, rf_write_en, rf_write_data_sel,
    input  const_val, alu_sel, alu_oper, op_emit,
    input  res_ready,
    output op_ready, is_zero_result, lt_result,
    output res_data, res_valid
  );
endinterface

// File: rtl/gcd_datapath_unit.sv
// GCD datapath: register file, ALU, write-back stage with forwarding,
// status flags and a one-entry result slot toward the host.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous reset, active-low
//   bus  - slave side of gcd_datapath_unit_if:
//          op_* / rf_* / alu_* / const_val : micro-op from controller
//          is_zero_result, lt_result       : registered ALU flags
//          res_data/res_valid/res_ready    : result channel to host
module gcd_datapath_unit #(
  parameter int DATA_W    = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic              clk,
  input  logic              rst,
  gcd_datapath_unit_if.slave bus
);

  localparam int NREG = 1 << ADDR_BITS;

  typedef logic [DATA_W-1:0]    word_t;
  typedef logic [ADDR_BITS-1:0] addr_t;

  word_t rf_q [NREG];
  word_t rf_d [NREG];

  logic  wb_valid_q, wb_valid_d;
  logic  wb_en_q, wb_en_d;
  addr_t wb_addr_q, wb_addr_d;
  word_t wb_data_q, wb_data_d;

  logic  zero_q, zero_d;
  logic  lt_q, lt_d;
  logic  res_valid_q, res_valid_d;
  word_t res_data_q, res_data_d;

  logic  op_ready;
  logic  accept;
  logic  wb_hit1, wb_hit2;
  logic  lt_now;
  word_t op1, rd2, op2, alu_res;

  // Only an emitting op needs the result slot.
  assign op_ready = !bus.op_emit || !res_valid_q
                    || bus.res_ready;
  assign accept   = bus.op_valid && op_ready;

  // A value sitting in write-back is not yet in the
  // register file, so bypass it to the readers.
  assign wb_hit1 = wb_valid_q && wb_en_q
                   && (wb_addr_q != '0)
                   && (wb_addr_q == bus.rf_read_addr1);
  assign wb_hit2 = wb_valid_q && wb_en_q
                   && (wb_addr_q != '0)
                   && (wb_addr_q == bus.rf_read_addr2);

  always_comb begin
    op1 = '0;
    if (bus.rf_read_addr1 != '0) begin
      op1 = wb_hit1 ? wb_data_q
                    : rf_q[bus.rf_read_addr1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (bus.rf_read_addr2 != '0) begin
      rd2 = wb_hit2 ? wb_data_q
                    : rf_q[bus.rf_read_addr2];
    end
  end

  assign op2    = bus.alu_sel ? bus.const_val : rd2;
  assign lt_now = op1 < op2;

  always_comb begin
    alu_res = op1;
    unique case (bus.alu_oper)
      2'b00: alu_res = op1 + op2;
      2'b01: alu_res = op1 - op2;
      2'b10: alu_res = {{(DATA_W-1){1'b0}}, lt_now};
      2'b11: alu_res = op1;
    endcase
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_valid_q && wb_en_q && wb_addr_q != '0) begin
      rf_d[wb_addr_q] = wb_data_q;
    end

    wb_valid_d  = accept;
    wb_en_d     = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    zero_d      = zero_q;
    lt_d        = lt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;

    if (accept) begin
      wb_en_d   = bus.rf_write_en;
      wb_addr_d = bus.rf_write_addr;
      wb_data_d = bus.rf_write_data_sel
                  ? bus.const_val : alu_res;
      // Flags track the ALU even on a const load.
      zero_d    = (alu_res == '0);
      lt_d      = lt_now;
    end

    // A new emit reloads the slot even as it drains.
    if (accept && bus.op_emit) begin
      res_valid_d = 1'b1;
      res_data_d  = wb_data_d;
    end else if (res_valid_q && bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
      wb_valid_q  <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      zero_q      <= 1'b1;
      lt_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      rf_q        <= rf_d;
      wb_valid_q  <= wb_valid_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      zero_q      <= zero_d;
      lt_q        <= lt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign bus.op_ready       = op_ready;
  assign bus.is_zero_result = zero_q;
  assign bus.lt_result      = lt_q;
  assign bus.res_valid      = res_valid_q;
  assign bus.res_data       = res_data_q;

endmodule
